// File: rtl/semiauto_planner.sv
// rtl/semiauto_planner.sv - semi-automatic drive planner: command queue feeding a crossroad turn FSM.
// Commands wait in a small FIFO and are consumed one per crossroad; turns and cooldowns are tick-timed.
module semiauto_planner #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 11,
  parameter int TURN_TICKS  = 200,
  parameter int UTURN_TICKS = 400,
  parameter int COOL_TICKS  = 50
) (
  input  logic                     clk_20ms,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [3:0]               detector,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd,
  input  logic                     flush,
  output logic [3:0]               moving_state,
  output logic [2:0]               fsm_state,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     q_empty,
  output logic                     cmd_drop
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_FWD  = 3'b001,
    S_WAIT = 3'b010,
    S_TURN = 3'b011,
    S_COOL = 3'b100
  } state_t;

  localparam logic [3:0] MV_STOP  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  localparam logic [CNT_W-1:0] TICK_MAX   = '1;
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(UTURN_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);

  state_t           state_q, state_d;
  logic [3:0]       move_q, move_d;
  logic [CNT_W-1:0] tick_q, tick_d, tick_inc;
  logic             uturn_q, uturn_d;
  logic             cross_q;

  logic [1:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, drop_q, drop_d;
  logic             pop, push_ok, push_w, pop_w;
  logic [1:0]       head;

  assign head     = mem_q[rd_ptr_q];
  assign tick_inc = (tick_q == TICK_MAX) ? tick_q : tick_q + CNT_W'(1);

  // The FSM acts on the head it sees in WAIT; flush only suppresses the queue update.
  assign pop     = (state_q == S_WAIT) && enable && !empty_q;
  assign push_ok = cmd_valid && (!full_q || pop);
  assign push_w  = push_ok && !flush;
  assign pop_w   = pop && !flush;
  assign drop_d  = cmd_valid && !flush && full_q && !pop;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    tick_d  = '0;
    uturn_d = uturn_q;
    if (!enable) begin
      state_d = S_IDLE;
      move_d  = MV_STOP;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          move_d  = MV_STOP;
        end
        S_FWD: begin
          move_d = MV_FWD;
          if (cross_q) begin
            state_d = S_WAIT;
            move_d  = MV_STOP;
          end
        end
        S_WAIT: begin
          move_d = MV_STOP;
          if (!empty_q) begin
            case (head)
              2'b00: begin
                state_d = S_COOL;
                move_d  = MV_FWD;
              end
              2'b01: begin
                state_d = S_TURN;
                move_d  = MV_LEFT;
                uturn_d = 1'b0;
              end
              2'b10: begin
                state_d = S_TURN;
                move_d  = MV_RIGHT;
                uturn_d = 1'b0;
              end
              default: begin
                state_d = S_TURN;
                move_d  = MV_RIGHT;
                uturn_d = 1'b1;
              end
            endcase
          end
        end
        S_TURN: begin
          // Leaving a turn inserts one STOP cycle before the cooldown drives forward.
          if (tick_q >= (uturn_q ? UTURN_LAST : TURN_LAST)) begin
            state_d = S_COOL;
            move_d  = MV_STOP;
          end else begin
            tick_d = tick_inc;
          end
        end
        S_COOL: begin
          move_d = MV_FWD;
          if (tick_q >= COOL_LAST) begin
            state_d = S_FWD;
          end else begin
            tick_d = tick_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          move_d  = MV_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk_20ms) begin
    if (rst) begin
      state_q  <= S_IDLE;
      move_q   <= MV_STOP;
      tick_q   <= '0;
      uturn_q  <= 1'b0;
      cross_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      tick_q  <= tick_d;
      uturn_q <= uturn_d;
      cross_q <= detector[0] | ~detector[1] | ~detector[2];
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
      drop_q  <= drop_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_20ms) begin
    if (!rst && push_w) mem_q[wr_ptr_q] <= cmd;
  end

  assign moving_state = move_q;
  assign fsm_state    = state_q;
  assign q_count      = count_q;
  assign q_full       = full_q;
  assign q_empty      = empty_q;
  assign cmd_drop     = drop_q;

endmodule

// File: tb/tb_semiauto_planner.sv
// tb/tb_semiauto_planner.sv - directed self-checking bench for semiauto_planner.
module tb_semiauto_planner;
  logic       clk_20ms = 1'b0;
  logic       rst, enable, cmd_valid, flush;
  logic [3:0] detector;
  logic [1:0] cmd;
  logic [3:0] moving_state;
  logic [2:0] fsm_state;
  logic [2:0] q_count;
  logic       q_full, q_empty, cmd_drop;
  int         checks = 0;
  int         errors = 0;

  localparam int IDLE = 0, FWD = 1, WAIT = 2, TURN = 3, COOL = 4;
  localparam int M_STOP = 0, M_FWD = 1, M_LEFT = 4, M_RIGHT = 8;
  localparam logic [3:0] D_CLEAR = 4'b0110;
  localparam logic [3:0] D_CROSS = 4'b0001;

  semiauto_planner dut (
    .clk_20ms(clk_20ms), .rst(rst), .enable(enable), .detector(detector),
    .cmd_valid(cmd_valid), .cmd(cmd), .flush(flush),
    .moving_state(moving_state), .fsm_state(fsm_state), .q_count(q_count),
    .q_full(q_full), .q_empty(q_empty), .cmd_drop(cmd_drop)
  );

  always #10 clk_20ms = ~clk_20ms;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_20ms);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input int s, input int m);
    chk({tag, ".state"}, int'(fsm_state), s);
    chk({tag, ".move"}, int'(moving_state), m);
  endtask

  task automatic qs(input string tag, input int cnt, input int full, input int empty, input int drop);
    chk({tag, ".count"}, int'(q_count), cnt);
    chk({tag, ".full"}, int'(q_full), full);
    chk({tag, ".empty"}, int'(q_empty), empty);
    chk({tag, ".drop"}, int'(cmd_drop), drop);
  endtask

  initial begin
    logic [1:0] vals [5];
    vals = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};

    // reset overrides enable and a pending push
    rst = 1'b1; enable = 1'b1; detector = D_CLEAR; cmd_valid = 1'b1; cmd = 2'b01; flush = 1'b0;
    step(2);
    st("reset", IDLE, M_STOP);
    qs("reset", 0, 0, 1, 0);

    cmd_valid = 1'b0; rst = 1'b0;
    step(1);
    st("idle_to_wait", WAIT, M_STOP);
    step(1);
    st("wait_empty", WAIT, M_STOP);

    // straight: no bypass, then cooldown of 50 forward cycles
    cmd = 2'b00; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    st("push_no_bypass", WAIT, M_STOP);
    chk("push_no_bypass.count", int'(q_count), 1);
    step(1);
    qs("straight_pop", 0, 0, 1, 0);
    for (int i = 0; i < 50; i++) begin
      st("straight_cool", COOL, M_FWD);
      step(1);
    end
    st("straight_to_fwd", FWD, M_FWD);

    // left turn at a crossroad
    cmd = 2'b01; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    st("fwd_push_left", FWD, M_FWD);
    chk("fwd_push_left.count", int'(q_count), 1);
    detector = D_CROSS;
    step(1);
    detector = D_CLEAR;
    st("cross_registered", FWD, M_FWD);
    step(1);
    st("cross_to_wait", WAIT, M_STOP);
    step(1);
    chk("left_pop.count", int'(q_count), 0);
    for (int i = 0; i < 200; i++) begin
      st("left_turn", TURN, M_LEFT);
      step(1);
    end
    st("left_cool_stop", COOL, M_STOP);
    step(1);
    for (int i = 0; i < 49; i++) begin
      st("left_cool_fwd", COOL, M_FWD);
      step(1);
    end
    st("left_to_fwd", FWD, M_FWD);

    // back pushed on the very edge that enters WAIT
    detector = D_CROSS;
    step(1);
    detector = D_CLEAR; cmd = 2'b11; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    st("back_enter_wait", WAIT, M_STOP);
    chk("back_enter_wait.count", int'(q_count), 1);
    step(1);
    for (int i = 0; i < 400; i++) begin
      st("uturn", TURN, M_RIGHT);
      step(1);
    end
    st("uturn_cool", COOL, M_STOP);
    step(50);
    st("uturn_to_fwd", FWD, M_FWD);

    // fill with enable low; fifth push is dropped
    enable = 1'b0;
    step(1);
    st("disable_idle", IDLE, M_STOP);
    for (int i = 0; i < 5; i++) begin
      cmd = vals[i]; cmd_valid = 1'b1;
      step(1);
      qs("fill", (i < 4) ? i + 1 : 4, (i >= 3) ? 1 : 0, 0, (i == 4) ? 1 : 0);
    end
    cmd_valid = 1'b0;
    step(1);
    qs("fill_idle", 4, 1, 0, 0);

    // full queue in WAIT with a same-cycle push
    enable = 1'b1;
    step(1);
    st("full_wait", WAIT, M_STOP);
    cmd = 2'b00; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    st("full_pop_push", TURN, M_LEFT);
    qs("full_pop_push", 4, 1, 0, 0);

    // reset mid-turn discards the queue
    step(100);
    st("turn_100", TURN, M_LEFT);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    st("reset_in_turn", IDLE, M_STOP);
    qs("reset_in_turn", 0, 0, 1, 0);

    // reach FWD with two commands queued, then drop enable
    step(1);
    cmd = 2'b00; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    step(1);
    st("cool_again", COOL, M_FWD);
    cmd = 2'b01; cmd_valid = 1'b1;
    step(1);
    cmd = 2'b10;
    step(1);
    cmd_valid = 1'b0;
    step(48);
    st("fwd_queued", FWD, M_FWD);
    chk("fwd_queued.count", int'(q_count), 2);
    enable = 1'b0;
    step(1);
    st("disable_retain", IDLE, M_STOP);
    qs("disable_retain", 2, 0, 0, 0);

    // flush beats a same-cycle push
    flush = 1'b1; cmd = 2'b11; cmd_valid = 1'b1;
    step(1);
    flush = 1'b0; cmd_valid = 1'b0;
    st("flush", IDLE, M_STOP);
    qs("flush", 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
